// File: rtl/stream_fifo_if.sv
// ---------------------------------------------------------------------------
// stream_fifo_if
//   Valid/ready stream bundle used on both sides of stream_fifo.
//
//   data   WIDTH  payload word, driven by the master
//   valid  1      payload is valid, driven by the master
//   ready  1      receiver accepts the word, driven by the slave
//
//   A word transfers on a rising edge where valid && ready.
// ---------------------------------------------------------------------------
interface stream_fifo_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface : stream_fifo_if

// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
//   Synchronous first-word-fall-through FIFO with valid/ready on both sides.
//   The head word, valid, ready and almost-full are all registered, so there
//   is no combinational path from either handshake input to the opposite
//   handshake output.
//
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous reset, active-high
//   clear_i        synchronous flush, active-high (data_o is kept)
//   wr_if          slave stream: data/valid in, ready out (ready = not full)
//   rd_if          master stream: data/valid out (valid = not empty), ready in
//   count_o        occupancy, 0..DEPTH
//   almost_full_o  count_o >= AFULL_LEVEL
//
//   DEPTH must be a power of two >= 2; the interface WIDTH must equal WIDTH.
// ---------------------------------------------------------------------------
module stream_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  stream_fifo_if.slave           wr_if,
  stream_fifo_if.master          rd_if,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   almost_full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  // Storage and state
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic             valid_q,  valid_d;
  logic             ready_q,  ready_d;
  logic             afull_q,  afull_d;

  logic push;
  logic pop;
  logic mem_we;

  // Handshakes use the registered status, so a write at full is refused even
  // when a pop happens in the same cycle.
  assign push   = wr_if.valid && ready_q;
  assign pop    = valid_q && rd_if.ready;
  assign mem_we = push && !clear_i && !rst_i;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;

    if (clear_i) begin
      // Flush: discard contents and any concurrent write, keep data_o.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      // Preload the next head. If the FIFO is empty after any pop, the word
      // being written this cycle is the new head and is bypassed from the
      // input, since it is not in memory yet. Empty keeps the last value.
      if (count_d != '0) begin
        if (push && (wr_ptr_q == rd_ptr_d)) data_d = wr_if.data;
        else                                data_d = mem_q[rd_ptr_d];
      end
    end

    valid_d = (count_d != '0);
    ready_d = (count_d <  DEPTH_C);
    afull_d = (count_d >= AFULL_C);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      afull_q  <= afull_d;
    end
  end

  // NOTE: the storage array has no reset; count and pointers define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_if.data;
  end

  assign wr_if.ready   = ready_q;
  assign rd_if.data    = data_q;
  assign rd_if.valid   = valid_q;
  assign count_o       = count_q;
  assign almost_full_o = afull_q;

endmodule : stream_fifo

// File: tb/tb_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo
//   Directed bench for stream_fifo (WIDTH=8, DEPTH=8, AFULL_LEVEL=6).
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, reflecting the edge just taken.
// ---------------------------------------------------------------------------
module tb_stream_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clear_i;
  logic [3:0] count_o;
  logic       almost_full_o;

  int checks = 0;
  int errors = 0;

  stream_fifo_if #(.WIDTH(8)) wr_if ();
  stream_fifo_if #(.WIDTH(8)) rd_if ();

  stream_fifo #(
    .WIDTH       (8),
    .DEPTH       (8),
    .AFULL_LEVEL (6)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .wr_if         (wr_if),
    .rd_if         (rd_if),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    wr_if.valid = 1'b0;
    wr_if.data  = 8'h00;
    rd_if.ready = 1'b0;
    clear_i     = 1'b0;
    rst_i       = 1'b0;
  endtask

  // Reset held two cycles while a write is offered; nothing may be stored.
  task automatic test_reset();
    idle_inputs();
    rst_i       = 1'b1;
    wr_if.valid = 1'b1;
    wr_if.data  = 8'hAA;
    step();
    step();
    checks++;
    if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
    checks++;
    if (rd_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rd_if.valid); end
    checks++;
    if (wr_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", wr_if.ready); end
    checks++;
    if (almost_full_o !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", almost_full_o); end
    checks++;
    if (rd_if.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rd_if.data); end
    idle_inputs();
    step();
    checks++;
    if (count_o !== 4'd0 || rd_if.valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_store: count %0d valid %b want 0 0", count_o, rd_if.valid);
    end
  endtask

  task automatic test_fall_through();
    idle_inputs();
    wr_if.valid = 1'b1;
    wr_if.data  = 8'h11;
    step();
    wr_if.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_if.valid !== 1'b1 || rd_if.data !== 8'h11 || count_o !== 4'd1) begin
        errors++;
        $display("FAIL fall_through_hold%0d: valid %b data %h count %0d want 1 11 1",
                 i, rd_if.valid, rd_if.data, count_o);
      end
      step();
    end
    rd_if.ready = 1'b1;
    step();
    rd_if.ready = 1'b0;
    checks++;
    if (rd_if.valid !== 1'b0 || count_o !== 4'd0) begin
      errors++; $display("FAIL fall_through_pop: valid %b count %0d want 0 0", rd_if.valid, count_o);
    end
    checks++;
    if (rd_if.data !== 8'h11) begin
      errors++; $display("FAIL empty_keeps_data: got %h want 11", rd_if.data);
    end
  endtask

  // Fill to full, refuse a write while full with a concurrent pop, then drain.
  task automatic test_fill_and_full();
    logic [7:0] w;
    idle_inputs();
    for (int i = 1; i <= 8; i++) begin
      w = 8'(i);
      wr_if.valid = 1'b1;
      wr_if.data  = w;
      step();
      checks++;
      if (count_o !== 4'(i) || almost_full_o !== (i >= 6) || wr_if.ready !== (i < 8)) begin
        errors++;
        $display("FAIL fill%0d: count %0d afull %b ready %b want %0d %b %b",
                 i, count_o, almost_full_o, wr_if.ready, i, (i >= 6), (i < 8));
      end
    end
    // Ninth write alone is refused.
    wr_if.data = 8'h09;
    step();
    checks++;
    if (count_o !== 4'd8 || wr_if.ready !== 1'b0) begin
      errors++; $display("FAIL full_refuse: count %0d ready %b want 8 0", count_o, wr_if.ready);
    end
    checks++;
    if (rd_if.data !== 8'h01) begin
      errors++; $display("FAIL full_head: got %h want 01", rd_if.data);
    end
    // Write and read together while full: only the pop happens.
    rd_if.ready = 1'b1;
    step();
    wr_if.valid = 1'b0;
    rd_if.ready = 1'b0;
    checks++;
    if (count_o !== 4'd7 || wr_if.ready !== 1'b1 || almost_full_o !== 1'b1) begin
      errors++;
      $display("FAIL full_rw: count %0d ready %b afull %b want 7 1 1", count_o, wr_if.ready, almost_full_o);
    end
    rd_if.ready = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      checks++;
      if (rd_if.valid !== 1'b1 || rd_if.data !== 8'(k)) begin
        errors++; $display("FAIL drain%0d: valid %b data %h want 1 %h", k, rd_if.valid, rd_if.data, 8'(k));
      end
      step();
    end
    rd_if.ready = 1'b0;
    checks++;
    if (rd_if.valid !== 1'b0 || count_o !== 4'd0 || almost_full_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: valid %b count %0d afull %b want 0 0 0", rd_if.valid, count_o, almost_full_o);
    end
  endtask

  // Write and read together at count=1: the new word becomes head.
  task automatic test_rw_at_one();
    idle_inputs();
    wr_if.valid = 1'b1;
    wr_if.data  = 8'hA0;
    step();
    wr_if.data  = 8'hB0;
    rd_if.ready = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (rd_if.valid !== 1'b1 || count_o !== 4'd1 || rd_if.data !== 8'hB0) begin
      errors++;
      $display("FAIL rw_at_one: valid %b count %0d data %h want 1 1 b0", rd_if.valid, count_o, rd_if.data);
    end
    rd_if.ready = 1'b1;
    step();
    rd_if.ready = 1'b0;
    checks++;
    if (count_o !== 4'd0) begin errors++; $display("FAIL rw_at_one_drain: count %0d want 0", count_o); end
  endtask

  // Random valid/ready stalls against a queue model.
  task automatic test_streaming();
    logic [7:0] q[$];
    logic [7:0] next_word;
    int sent = 0;
    int recv = 0;
    int cycles = 0;
    int pops = 0;
    int bad = 0;
    logic push_m;
    logic pop_m;
    idle_inputs();
    while ((sent < 100 || recv < 100) && cycles < 3000) begin
      next_word   = 8'($urandom);
      wr_if.valid = (sent < 100) && ($urandom_range(0, 9) < 7);
      wr_if.data  = next_word;
      rd_if.ready = ($urandom_range(0, 9) < 6);
      #0;
      if (count_o !== 4'(q.size()) || count_o > 4'd8 ||
          wr_if.ready !== (q.size() < 8) || rd_if.valid !== (q.size() != 0) ||
          (q.size() != 0 && rd_if.data !== q[0])) begin
        bad++;
        if (bad <= 5)
          $display("FAIL stream_cycle%0d: count %0d valid %b data %h want %0d %b %h",
                   cycles, count_o, rd_if.valid, rd_if.data, q.size(), (q.size() != 0),
                   (q.size() != 0) ? q[0] : 8'h00);
      end
      push_m = wr_if.valid && (q.size() < 8);
      pop_m  = rd_if.ready && (q.size() != 0);
      step();
      if (pop_m) begin void'(q.pop_front()); recv++; pops++; end
      if (push_m) begin q.push_back(next_word); sent++; end
      cycles++;
    end
    idle_inputs();
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stream_order: %0d bad cycles want 0", bad); end
    checks++;
    if (sent != 100 || recv != 100) begin
      errors++; $display("FAIL stream_timeout: sent %0d recv %0d want 100 100", sent, recv);
    end
    checks++;
    if (pops / 8 < 10) begin errors++; $display("FAIL stream_wraps: got %0d want >=10", pops / 8); end
  endtask

  // Clear with a concurrent write at count=5, then a reset mid-burst.
  task automatic test_clear();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      wr_if.valid = 1'b1;
      wr_if.data  = 8'(8'h51 + i);
      step();
    end
    checks++;
    if (count_o !== 4'd5) begin errors++; $display("FAIL clear_pre: count %0d want 5", count_o); end
    clear_i    = 1'b1;
    wr_if.data = 8'hEE;
    step();
    idle_inputs();
    checks++;
    if (count_o !== 4'd0 || rd_if.valid !== 1'b0 || wr_if.ready !== 1'b1 || almost_full_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: count %0d valid %b ready %b afull %b want 0 0 1 0",
               count_o, rd_if.valid, wr_if.ready, almost_full_o);
    end
    checks++;
    if (rd_if.data !== 8'h51) begin errors++; $display("FAIL clear_data_kept: got %h want 51", rd_if.data); end
    wr_if.valid = 1'b1;
    wr_if.data  = 8'h77;
    step();
    idle_inputs();
    checks++;
    if (rd_if.valid !== 1'b1 || rd_if.data !== 8'h77 || count_o !== 4'd1) begin
      errors++;
      $display("FAIL clear_first_word: valid %b data %h count %0d want 1 77 1", rd_if.valid, rd_if.data, count_o);
    end
    // Reset during a burst discards everything and zeroes data_o.
    wr_if.valid = 1'b1;
    wr_if.data  = 8'h33;
    step();
    step();
    rst_i = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (count_o !== 4'd0 || rd_if.valid !== 1'b0 || rd_if.data !== 8'h00) begin
      errors++;
      $display("FAIL midburst_reset: count %0d valid %b data %h want 0 0 00", count_o, rd_if.valid, rd_if.data);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fall_through();
    test_fill_and_full();
    test_rw_at_one();
    test_streaming();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_stream_fifo
